// File: rtl/ym_write_sched.sv
// Write scheduler between the host-bus synchronizer and the YM2151 core.
// Host writes are queued in a FIFO and replayed in order. Each write gets a
// strobe whose setup, hold and recovery are measured in whole ym_tick periods.
// Data writes wait for the core to drop busy; address writes never wait.
module ym_write_sched #(
  parameter int DEPTH      = 8,
  parameter int HOLD_TICKS = 2,
  parameter int GAP_TICKS  = 2
) (
  input  logic                       mclk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic                       in_a0,
  input  logic [7:0]                 in_data,
  input  logic                       ym_tick,
  input  logic                       ym_busy,
  input  logic                       clr_ovf,
  output logic                       ym_wr_n,
  output logic                       ym_a0,
  output logic [7:0]                 ym_din,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       overflow,
  output logic                       busy_out
);

  localparam int AW   = $clog2(DEPTH);
  localparam int MAXT = (HOLD_TICKS > GAP_TICKS) ? HOLD_TICKS : GAP_TICKS;
  localparam int CW   = $clog2(MAXT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    STROBE  = 2'd2,
    RECOVER = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [8:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   tick_cnt;
  logic [8:0]      head;
  logic            pop;
  logic            push;
  logic            drop;
  logic            cnt_clr;
  logic            cnt_inc;

  assign head = mem[rd_ptr];

  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign push = in_valid && ((fifo_level < (AW + 1)'(DEPTH)) || pop);
  assign drop = in_valid && !push;

  // State register; reset parks the sequencer in IDLE.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state decode: issue from IDLE, then count ticks through each phase.
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    case (state)
      IDLE: begin
        if ((fifo_level != '0) && (!head[8] || !ym_busy)) begin
          pop      = 1'b1;
          cnt_clr  = 1'b1;
          state_nx = SETUP;
        end
      end
      SETUP: begin
        if (ym_tick) begin
          cnt_clr  = 1'b1;
          state_nx = STROBE;
        end
      end
      STROBE: begin
        if (ym_tick) begin
          if (tick_cnt == CW'(HOLD_TICKS - 1)) begin
            cnt_clr  = 1'b1;
            state_nx = RECOVER;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      RECOVER: begin
        if (ym_tick) begin
          if (tick_cnt == CW'(GAP_TICKS - 1)) begin
            cnt_clr  = 1'b1;
            state_nx = IDLE;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      default: begin
        cnt_clr  = 1'b1;
        state_nx = IDLE;
      end
    endcase
  end

  // Tick counter, restarted on each state entry so entry-cycle ticks never count.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst)          tick_cnt <= '0;
    else if (cnt_clr) tick_cnt <= '0;
    else if (cnt_inc) tick_cnt <= tick_cnt + CW'(1);
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge mclk) begin
    if (push) mem[wr_ptr] <= {in_a0, in_data};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + (AW + 1)'(1);
        2'b01:   fifo_level <= fifo_level - (AW + 1)'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Issued write is latched on pop and held through SETUP, STROBE and RECOVER.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      ym_a0  <= 1'b0;
      ym_din <= 8'h00;
    end else if (pop) begin
      ym_a0  <= head[8];
      ym_din <= head[7:0];
    end
  end

  // Strobe is registered from the next state so it is low exactly while in STROBE.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) ym_wr_n <= 1'b1;
    else     ym_wr_n <= (state_nx != STROBE);
  end

  // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst)          overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

  // Host busy: anything queued, in flight, or the core itself still busy.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) busy_out <= 1'b0;
    else     busy_out <= ym_busy | (fifo_level != '0) | (state != IDLE);
  end

endmodule
